// File: rtl/alu_seq_core.sv
// alu_seq_core: sequential ALU, one-cycle logic/add/sub, N-cycle mul/div.
// Optional flag outputs are enabled with `define ALU_SEQ_FLAGS_EN.
module alu_seq_core #(
  parameter int N = 8
) (
  input  logic           clk,
  input  logic           reset,
  input  logic           in_valid,
  input  logic [N-1:0]   inp1,
  input  logic [N-1:0]   inp2,
  input  logic [2:0]     op_code,
  output logic           busy,
  output logic           out_valid,
  output logic [2*N-1:0] alu_out
`ifdef ALU_SEQ_FLAGS_EN
  ,
  output logic           flag_zero,
  output logic           flag_carry,
  output logic           flag_dz
`endif
);

  localparam int CW = $clog2(N);

  localparam logic [2:0] OP_ADD = 3'b000;
  localparam logic [2:0] OP_SUB = 3'b001;
  localparam logic [2:0] OP_MUL = 3'b010;
  localparam logic [2:0] OP_DIV = 3'b011;
  localparam logic [2:0] OP_AND = 3'b100;
  localparam logic [2:0] OP_OR  = 3'b101;
  localparam logic [2:0] OP_XOR = 3'b110;
  localparam logic [2:0] OP_NOT = 3'b111;

  typedef enum logic [1:0] {
    S_IDLE,
    S_MUL,
    S_DIV
  } state_t;

  state_t         state;
  logic [CW-1:0]  cnt;
  logic [N-1:0]   b_q;
  logic [N-1:0]   mplier;
  logic [2*N-1:0] mcand;
  logic [2*N-1:0] prod;
  logic [N-1:0]   rem;
  logic [N-1:0]   quo;

  logic           accept;
  logic           last;
  logic [2*N-1:0] ext_a;
  logic [2*N-1:0] ext_b;
  logic [2*N-1:0] alu_res;
  logic           carry;
  logic [2*N-1:0] prod_nxt;
  logic [N:0]     r_shift;
  logic           ge;
  logic [N-1:0]   rem_nxt;
  logic [N-1:0]   quo_nxt;

  assign accept = in_valid && !busy;
  assign last   = (cnt == CW'(N - 1));
  assign ext_a  = {{N{1'b0}}, inp1};
  assign ext_b  = {{N{1'b0}}, inp2};

  always_comb begin
    alu_res = '0;
    carry   = 1'b0;
    unique case (op_code)
      OP_ADD: begin
        alu_res = ext_a + ext_b;
        carry   = alu_res[N];
      end
      OP_SUB: begin
        alu_res = ext_a - ext_b;
        carry   = (inp1 < inp2);
      end
      OP_AND: alu_res = ext_a & ext_b;
      OP_OR:  alu_res = ext_a | ext_b;
      OP_XOR: alu_res = ext_a ^ ext_b;
      OP_NOT: alu_res = {{N{1'b0}}, ~inp1};
      default: alu_res = '0;
    endcase
  end

  // Shift-add multiply step and restoring divide step.
  // A zero divisor always "fits", giving q=all ones and r=A for free.
  always_comb begin
    prod_nxt = mplier[0] ? prod + mcand : prod;
    r_shift  = {rem, quo[N-1]};
    ge       = (r_shift >= {1'b0, b_q});
    rem_nxt  = N'(ge ? r_shift - {1'b0, b_q} : r_shift);
    quo_nxt  = {quo[N-2:0], ge};
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= S_IDLE;
      cnt       <= '0;
      busy      <= 1'b0;
      out_valid <= 1'b0;
      alu_out   <= '0;
      b_q       <= '0;
      mplier    <= '0;
      mcand     <= '0;
      prod      <= '0;
      rem       <= '0;
      quo       <= '0;
`ifdef ALU_SEQ_FLAGS_EN
      flag_zero  <= 1'b0;
      flag_carry <= 1'b0;
      flag_dz    <= 1'b0;
`endif
    end else begin
      out_valid <= 1'b0;
      unique case (state)
        S_IDLE: begin
          if (accept) begin
            unique case (op_code)
              OP_MUL: begin
                state  <= S_MUL;
                busy   <= 1'b1;
                cnt    <= '0;
                prod   <= '0;
                mcand  <= ext_a;
                mplier <= inp2;
              end
              OP_DIV: begin
                state <= S_DIV;
                busy  <= 1'b1;
                cnt   <= '0;
                rem   <= '0;
                quo   <= inp1;
                b_q   <= inp2;
              end
              default: begin
                alu_out   <= alu_res;
                out_valid <= 1'b1;
`ifdef ALU_SEQ_FLAGS_EN
                flag_zero  <= (alu_res == '0);
                flag_carry <= carry;
                flag_dz    <= 1'b0;
`endif
              end
            endcase
          end
        end
        S_MUL: begin
          prod   <= prod_nxt;
          mcand  <= mcand << 1;
          mplier <= mplier >> 1;
          cnt    <= cnt + 1'b1;
          if (last) begin
            state     <= S_IDLE;
            busy      <= 1'b0;
            cnt       <= '0;
            alu_out   <= prod_nxt;
            out_valid <= 1'b1;
`ifdef ALU_SEQ_FLAGS_EN
            flag_zero  <= (prod_nxt == '0);
            flag_carry <= 1'b0;
            flag_dz    <= 1'b0;
`endif
          end
        end
        S_DIV: begin
          rem <= rem_nxt;
          quo <= quo_nxt;
          cnt <= cnt + 1'b1;
          if (last) begin
            state     <= S_IDLE;
            busy      <= 1'b0;
            cnt       <= '0;
            alu_out   <= {rem_nxt, quo_nxt};
            out_valid <= 1'b1;
`ifdef ALU_SEQ_FLAGS_EN
            flag_zero  <= ({rem_nxt, quo_nxt} == '0);
            flag_carry <= 1'b0;
            flag_dz    <= (b_q == '0);
`endif
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_alu_seq_core.sv
// tb_alu_seq_core: random + directed scoreboard bench for alu_seq_core.
// Flag outputs are checked when ALU_SEQ_FLAGS_EN is defined.
module tb_alu_seq_core;

  localparam int N = 8;

  logic           clk = 1'b0;
  logic           reset = 1'b1;
  logic           in_valid = 1'b0;
  logic [N-1:0]   inp1 = '0;
  logic [N-1:0]   inp2 = '0;
  logic [2:0]     op_code = '0;
  logic           busy;
  logic           out_valid;
  logic [2*N-1:0] alu_out;
`ifdef ALU_SEQ_FLAGS_EN
  logic           flag_zero;
  logic           flag_carry;
  logic           flag_dz;
`endif

  alu_seq_core #(.N(N)) dut (
    .clk       (clk),
    .reset     (reset),
    .in_valid  (in_valid),
    .inp1      (inp1),
    .inp2      (inp2),
    .op_code   (op_code),
    .busy      (busy),
    .out_valid (out_valid),
    .alu_out   (alu_out)
`ifdef ALU_SEQ_FLAGS_EN
    ,
    .flag_zero (flag_zero),
    .flag_carry(flag_carry),
    .flag_dz   (flag_dz)
`endif
  );

  always #5 clk = ~clk;

  typedef struct {
    int             due;
    logic [2*N-1:0] res;
    logic           zf;
    logic           cf;
    logic           dzf;
  } exp_t;

  exp_t           q[$];
  int             cyc = 0;
  int             free_at = 0;
  logic [2*N-1:0] exp_out = '0;
  int             checks = 0;
  int             errors = 0;

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s at edge %0d: got %h expected %h", nm, cyc, act, exp);
    end
  endtask

  function automatic logic [2*N-1:0] model(input logic [2:0] op,
                                           input int unsigned a,
                                           input int unsigned b);
    int unsigned r;
    int unsigned m2 = (1 << (2 * N)) - 1;
    int unsigned m1 = (1 << N) - 1;
    case (op)
      3'd0: r = a + b;
      3'd1: r = (a - b) & m2;
      3'd2: r = a * b;
      3'd3: r = (b == 0) ? ((a << N) | m1) : (((a % b) << N) | (a / b));
      3'd4: r = a & b;
      3'd5: r = a | b;
      3'd6: r = a ^ b;
      default: r = (~a) & m1;
    endcase
    return r[2*N-1:0];
  endfunction

  // Driver: presents one request per cycle and predicts acceptance.
  task automatic step(input logic v, input logic [2:0] op,
                      input logic [N-1:0] a, input logic [N-1:0] b,
                      input logic use_k, input logic [2*N-1:0] k);
    exp_t e;
    int   ed;
    logic iter;
    in_valid = v;
    op_code  = op;
    inp1     = a;
    inp2     = b;
    ed = cyc + 1;
    if (v && !reset && ed >= free_at) begin
      e.res = use_k ? k : model(op, a, b);
      e.zf  = (e.res == '0);
      e.cf  = (op == 3'd0 && (int'(a) + int'(b)) > (1 << N) - 1) ||
              (op == 3'd1 && a < b);
      e.dzf = (op == 3'd3 && b == '0);
      iter  = (op == 3'd2 || op == 3'd3);
      e.due = iter ? ed + N : ed;
      free_at = iter ? ed + N + 1 : ed + 1;
      q.push_back(e);
    end
    @(negedge clk);
  endtask

  task automatic idle(input int n);
    repeat (n) step(1'b0, 3'd0, '0, '0, 1'b0, '0);
  endtask

  task automatic do_reset(input int n);
    reset    = 1'b1;
    in_valid = 1'b0;
    q.delete();
    exp_out  = '0;
    free_at  = 0;
    repeat (n) @(negedge clk);
    reset   = 1'b0;
    free_at = cyc + 1;
  endtask

  // Monitor: checks outputs #1 after every rising edge.
  initial begin
    exp_t e;
    logic ev;
    forever begin
      @(posedge clk);
      #1;
      cyc++;
      ev = (q.size() > 0) && (q[0].due == cyc);
      chk("out_valid", 32'(out_valid), 32'(ev));
      if (ev) begin
        e = q.pop_front();
        exp_out = e.res;
`ifdef ALU_SEQ_FLAGS_EN
        chk("flag_zero", 32'(flag_zero), 32'(e.zf));
        chk("flag_carry", 32'(flag_carry), 32'(e.cf));
        chk("flag_dz", 32'(flag_dz), 32'(e.dzf));
`endif
      end
      chk("alu_out", 32'(alu_out), 32'(exp_out));
      chk("busy", 32'(busy), 32'(cyc < free_at - 1));
    end
  end

  initial begin
    logic [2:0]   op;
    logic [N-1:0] a;
    logic [N-1:0] b;
    @(negedge clk);
    do_reset(3);

    step(1'b1, 3'd0, 8'hFF, 8'h01, 1'b1, 16'h0100);
    step(1'b1, 3'd1, 8'h03, 8'h05, 1'b1, 16'hFFFE);
    step(1'b1, 3'd6, 8'hAA, 8'hFF, 1'b1, 16'h0055);
    idle(1);

    step(1'b1, 3'd2, 8'hFF, 8'hFF, 1'b1, 16'hFE01);
    repeat (N) step(1'b1, 3'd0, 8'h01, 8'h02, 1'b0, '0);
    step(1'b1, 3'd7, 8'h0F, 8'h00, 1'b1, 16'h00F0);
    idle(1);

    step(1'b1, 3'd3, 8'd200, 8'd7, 1'b1, 16'h041C);
    idle(N);
    step(1'b1, 3'd3, 8'd42, 8'd0, 1'b1, 16'h2AFF);
    idle(N + 1);

    step(1'b1, 3'd2, 8'h12, 8'h34, 1'b1, 16'h03A8);
    idle(3);
    do_reset(1);
    step(1'b1, 3'd0, 8'h01, 8'h01, 1'b1, 16'h0002);
    idle(2);

    for (int i = 0; i < 600; i++) begin
      op = 3'($urandom_range(0, 7));
      a  = N'($urandom);
      b  = N'($urandom);
      case ($urandom_range(0, 9))
        0: a = '1;
        1: b = '0;
        2: b = '1;
        3: a = '0;
        default: ;
      endcase
      if ($urandom_range(0, 79) == 0) do_reset(1 + $urandom_range(0, 1));
      else step(1'($urandom_range(0, 4) != 0), op, a, b, 1'b0, '0);
    end

    idle(N + 3);
    chk("queue_drained", 32'(q.size()), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/alu_seq_core.md
Name: alu_seq_core

Overview:
- Sequential ALU: the responder end of the `alu_intf` operand/op-code/result protocol.
- Sits under the UVM environment as the DUT. Accepts `inp1`, `inp2` and `op_code` on an in_valid handshake and returns a 2N-bit `alu_out` with an out_valid strobe.
- Logic ops, ADD and SUB take one cycle. MUL and DIV are iterative, taking N cycles with busy back-pressure.

Parameters:
N, 8, operand width; result width is 2N; must be at least 2.

Ports:
clk       input   1     clock, rising edge
reset     input   1     synchronous, active-high reset
in_valid  input   1     request strobe; sampled with inp1/inp2/op_code
inp1      input   N     operand A, unsigned
inp2      input   N     operand B, unsigned
op_code   input   3     operation select
busy      output  1     iterative op in progress; requests are dropped while high
out_valid output  1     one-cycle pulse; alu_out updated this cycle
alu_out   output  2N    result register; holds its value between results

Behaviour:
- Interface: single clock `clk`; `reset` is synchronous, active-high, sampled on rising `clk`.
- Reset values: `alu_out`=0, `out_valid`=0, `busy`=0, FSM=IDLE, iteration counter=0.
- Reset mid-operation aborts the op: no `out_valid`, `alu_out` cleared.
- Accept condition: `in_valid` && !`busy` at a rising edge. `in_valid` while `busy` is ignored; there is no queueing.
- Op codes and results:
  - 000 ADD: {N'b0, A} + {N'b0, B}. Carry lands in bit N.
  - 001 SUB: A − B in two's complement, sign-extended to 2N. Example: 3−5 gives all-ones upper bits.
  - 010 MUL: A×B unsigned, full 2N result.
  - 011 DIV: quotient in `alu_out[N-1:0]`, remainder in `alu_out[2N-1:N]`.
  - 100 AND, 101 OR, 110 XOR: bitwise on A,B, zero-extended.
  - 111 NOT: ~A, zero-extended; B ignored.
- Divide by zero: quotient = all ones, remainder = A.
- Single-cycle ops (ADD/SUB/AND/OR/XOR/NOT):
  - Request accepted at edge k: `alu_out` loaded and `out_valid`=1 after edge k, i.e. latency 1.
  - Back-to-back requests every cycle give `out_valid` every cycle.
- FSM states: IDLE, MUL, DIV.
  - IDLE→MUL / IDLE→DIV on accept of 010/011. Operands latch and `busy` goes to 1 after edge k.
  - MUL: one shift-add step per edge, k+1..k+N.
  - DIV: one restoring shift-subtract step per edge, k+1..k+N.
  - Counter counts 0..N−1. At edge k+N the result loads into `alu_out`, `out_valid`=1, `busy`=0, and the FSM returns to IDLE.
  - `busy` is high for exactly N cycles.
  - A new request is accepted in the same cycle `out_valid` of an iterative op is high, since `busy`=0.
- Operands are latched at accept; input changes during `busy` have no effect.
- `out_valid` is never high two cycles for one request. `alu_out` changes only on `out_valid` or on reset.

Optional Feature:
- Macro: ALU_SEQ_FLAGS_EN.
- When defined, adds three outputs, all registered and updated together with `out_valid`; reset value 0.
  - flag_zero (1): `alu_out` == 0.
  - flag_carry (1): ADD bit N set, or SUB borrow (A<B); 0 for other ops.
  - flag_dz (1): DIV with B==0.
- When undefined, the ports and logic are absent. All other behaviour is identical.

Test Plan:
- Reset, then ADD with A=0xFF, B=0x01, `in_valid` 1 cycle → next cycle `out_valid`=1, `alu_out`=0x0100; flag_carry=1 if enabled.
- SUB with A=3, B=5 → `alu_out`=0xFFFE after 1 cycle. Then XOR with A=0xAA, B=0xFF on the next cycle → `alu_out`=0x0055 the cycle after.
- MUL with A=0xFF, B=0xFF → `busy` high exactly 8 cycles, then `out_valid`=1 with `alu_out`=0xFE01. An ADD presented during `busy` is dropped: no extra `out_valid`.
- DIV with A=200, B=7 → after 8 cycles `alu_out`=0x041C (q=28, r=4).
- DIV with A=42, B=0 → after 8 cycles `alu_out`=0x2AFF; flag_dz=1 if enabled.
- Start MUL with A=0x12, B=0x34, assert `reset` at iteration 4 → `busy`=0, `alu_out`=0, no `out_valid`. A following ADD 1+1 → 0x0002 after 1 cycle.
